// File: rtl/mouse_event_bus_bridge_pkg.sv
// Shared constants for the mouse event bus bridge: register offsets,
// control/flag bit positions and the packed event-entry width.
package mouse_bus_pkg;

  typedef enum logic [2:0] {
    OFS_STATUS = 3'd0,
    OFS_X      = 3'd1,
    OFS_Y      = 3'd2,
    OFS_Z      = 3'd3,
    OFS_FLAGS  = 3'd4,
    OFS_CTRL   = 3'd5
  } reg_ofs_e;

  localparam int CTRL_POP   = 0;
  localparam int CTRL_FLUSH = 1;
  localparam int CTRL_INTEN = 2;

  localparam int FLAG_OVF   = 7;
  localparam int FLAG_FULL  = 6;
  localparam int FLAG_EMPTY = 5;
  localparam int FLAG_CNT_W = 5;

  // Entry layout is {status, x, y, z}, status in the MSBs.
  function automatic int entry_w(input int status_w, input int coord_w);
    return status_w + 3 * coord_w;
  endfunction

endpackage

// File: rtl/mouse_event_bus_bridge_if.sv
// Processor-side control signals of the mouse bridge; the tri-state data
// byte stays a plain port on the bridge so its resolution lives at one level.
interface mouse_bus_if;
  logic [7:0] BUS_ADDR;
  logic       BUS_WE;
  logic       INT_ACK;
  logic       INT_RAISE;

  modport master (output BUS_ADDR, BUS_WE, INT_ACK, input INT_RAISE);
  modport slave  (input BUS_ADDR, BUS_WE, INT_ACK, output INT_RAISE);
endinterface

// File: rtl/mouse_event_bus_bridge_fifo.sv
// Single-clock event FIFO; flush dominates, and a pop frees the slot for a
// same-cycle push even when full.
module mouse_evt_fifo #(
  parameter int WIDTH = 28,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   push_ok
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign pop_ok  = pop && !empty && !flush;
  assign push_ok = push && !flush && (!full || pop_ok);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

endmodule

// File: rtl/mouse_event_bus_bridge.sv
// Memory-mapped bridge from the PS/2 mouse transceiver to the processor bus:
// event FIFO, shadow entry, control register, interrupt and read-back driver.
module mouse_event_bus_bridge
  import mouse_bus_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR  = 8'hA0,
  parameter int         FIFO_DEPTH = 4,
  parameter int         COORD_W    = 8,
  parameter int         STATUS_W   = 4,
  parameter int         Y_ORIGIN   = 120,
  parameter bit         Y_INVERT   = 1'b1
) (
  input  logic                CLK,
  input  logic                RESET,
  inout  wire  [7:0]          BUS_DATA,
  mouse_bus_if.slave          bus,
  input  logic                SEND_INTERRUPT,
  input  logic [STATUS_W-1:0] MOUSE_STATUS,
  input  logic [COORD_W-1:0]  MOUSE_X,
  input  logic [COORD_W-1:0]  MOUSE_Y,
  input  logic [COORD_W-1:0]  MOUSE_Z
);
  localparam int         EW        = entry_w(STATUS_W, COORD_W);
  localparam int         CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [7:0] CTRL_ADDR = BASE_ADDR + 8'(OFS_CTRL);

  logic [EW-1:0]       pkt, head, shadow, sel;
  logic [CW-1:0]       count;
  logic                full, empty, push_ok;
  logic                ovf, int_en, int_q, drv_en;
  logic [7:0]          dout, rd_mux;
  logic [2:0]          ofs;
  logic                rd_hit, ctrl_wr, pop_wr, flush_wr;
  logic [STATUS_W-1:0] f_st;
  logic [COORD_W-1:0]  f_x, f_y, f_z, y_bus;

  assign pkt = {MOUSE_STATUS, MOUSE_X, MOUSE_Y, MOUSE_Z};

  // Offset is only trusted when the address is at or above the base, so the
  // subtraction cannot wrap into the window.
  assign ofs      = 3'(bus.BUS_ADDR - BASE_ADDR);
  assign rd_hit   = !bus.BUS_WE && (bus.BUS_ADDR >= BASE_ADDR) &&
                    (8'(bus.BUS_ADDR - BASE_ADDR) <= 8'(OFS_CTRL));
  assign ctrl_wr  = bus.BUS_WE && (bus.BUS_ADDR == CTRL_ADDR);
  assign pop_wr   = ctrl_wr && BUS_DATA[CTRL_POP];
  assign flush_wr = ctrl_wr && BUS_DATA[CTRL_FLUSH];

  mouse_evt_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (CLK),
    .rst     (RESET),
    .push    (SEND_INTERRUPT),
    .pop     (pop_wr),
    .flush   (flush_wr),
    .wdata   (pkt),
    .head    (head),
    .count   (count),
    .full    (full),
    .empty   (empty),
    .push_ok (push_ok)
  );

  // With nothing queued the data registers fall back to the last packet seen.
  assign sel   = empty ? shadow : head;
  assign f_st  = sel[EW-1 -: STATUS_W];
  assign f_x   = sel[3*COORD_W-1 -: COORD_W];
  assign f_y   = sel[2*COORD_W-1 -: COORD_W];
  assign f_z   = sel[COORD_W-1:0];
  assign y_bus = Y_INVERT ? (COORD_W'(Y_ORIGIN) - f_y) : f_y;

  always_comb begin
    rd_mux = '0;
    case (ofs)
      OFS_STATUS: rd_mux = 8'(f_st);
      OFS_X:      rd_mux = 8'(f_x);
      OFS_Y:      rd_mux = 8'(y_bus);
      OFS_Z:      rd_mux = 8'(f_z);
      OFS_FLAGS: begin
        rd_mux[FLAG_OVF]          = ovf;
        rd_mux[FLAG_FULL]         = full;
        rd_mux[FLAG_EMPTY]        = empty;
        rd_mux[FLAG_CNT_W-1:0]    = FLAG_CNT_W'(count);
      end
      OFS_CTRL:   rd_mux[CTRL_INTEN] = int_en;
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      shadow <= '0;
      ovf    <= 1'b0;
      int_en <= 1'b1;
      int_q  <= 1'b0;
      drv_en <= 1'b0;
      dout   <= '0;
    end else begin
      if (SEND_INTERRUPT) shadow <= pkt;

      if (flush_wr)                       ovf <= 1'b0;
      else if (SEND_INTERRUPT && !push_ok) ovf <= 1'b1;

      if (ctrl_wr) int_en <= BUS_DATA[CTRL_INTEN];

      // A successful push wins over a same-cycle acknowledge.
      if (push_ok && int_en)
        int_q <= 1'b1;
      else if (bus.INT_ACK || (ctrl_wr && !BUS_DATA[CTRL_INTEN]))
        int_q <= 1'b0;

      drv_en <= rd_hit;
      if (rd_hit) dout <= rd_mux;
    end
  end

  assign bus.INT_RAISE = int_q;
  assign BUS_DATA      = drv_en ? dout : 8'hzz;

endmodule

// File: tb/tb_mouse_event_bus_bridge.sv
// Self-checking bench for mouse_event_bus_bridge: directed scenarios plus a
// randomized run against a queue-based model of the event FIFO.
module tb_mouse_event_bus_bridge;
  localparam logic [7:0] BASE   = 8'hA0;
  localparam logic [7:0] CTRL_A = 8'hA5;
  localparam int         DEPTH  = 4;
  localparam int         YORG   = 120;

  typedef struct packed {
    logic [3:0] st;
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] z;
  } ent_t;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       send = 1'b0;
  logic [3:0] m_st = '0;
  logic [7:0] m_x = '0, m_y = '0, m_z = '0;
  logic       tb_oe = 1'b0;
  logic [7:0] tb_drv = '0;
  wire  [7:0] bus_data;

  assign bus_data = tb_oe ? tb_drv : 8'hzz;
  pullup (bus_data);

  mouse_bus_if bus ();

  mouse_event_bus_bridge #(
    .BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .COORD_W(8), .STATUS_W(4),
    .Y_ORIGIN(YORG), .Y_INVERT(1'b1)
  ) dut (
    .CLK(CLK), .RESET(RESET), .BUS_DATA(bus_data), .bus(bus),
    .SEND_INTERRUPT(send), .MOUSE_STATUS(m_st),
    .MOUSE_X(m_x), .MOUSE_Y(m_y), .MOUSE_Z(m_z)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  ent_t q[$];
  ent_t shadow_m;
  bit   ovf_m, inten_m, int_m;

  function automatic ent_t rnd();
    ent_t e;
    e.st = 4'($urandom);
    e.x  = 8'($urandom);
    e.y  = 8'($urandom);
    e.z  = 8'($urandom);
    return e;
  endfunction

  function automatic logic [7:0] exp_rd(input logic [2:0] o);
    ent_t e;
    e = (q.size() != 0) ? q[0] : shadow_m;
    case (o)
      3'd0:    return {4'h0, e.st};
      3'd1:    return e.x;
      3'd2:    return 8'(YORG) - e.y;
      3'd3:    return e.z;
      3'd4:    return {ovf_m, q.size() == DEPTH, q.size() == 0, 5'(q.size())};
      3'd5:    return {5'b0, inten_m, 2'b00};
      default: return 8'hFF;
    endcase
  endfunction

  // One clock cycle of stimulus; the model advances by the same cycle.
  task automatic step(input bit push, input ent_t p, input bit we,
                      input logic [7:0] addr, input logic [7:0] wd, input bit ack);
    bit cw, popped, pushed;
    send = push; m_st = p.st; m_x = p.x; m_y = p.y; m_z = p.z;
    bus.BUS_WE = we; bus.BUS_ADDR = addr; bus.INT_ACK = ack;
    tb_oe = we; tb_drv = we ? wd : 8'h00;
    cw = we && (addr == CTRL_A);
    pushed = 0; popped = 0;
    if (cw && wd[1]) begin
      q.delete();
      ovf_m = 0;
    end else begin
      popped = cw && wd[0] && (q.size() != 0);
      if (push) begin
        if (q.size() < DEPTH || popped) pushed = 1;
        else ovf_m = 1;
      end
      if (popped) void'(q.pop_front());
      if (pushed) q.push_back(p);
    end
    if (push) shadow_m = p;
    if (pushed && inten_m) int_m = 1;
    else if (ack || (cw && !wd[2])) int_m = 0;
    if (cw) inten_m = wd[2];
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    step(0, rnd(), 0, 8'h00, 8'h00, 0);
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] v);
    step(0, rnd(), 0, a, 8'h00, 0);
    v = bus_data;
    idle();
  endtask

  task automatic test_reset();
    logic [7:0] v;
    logic [7:0] exp [6];
    exp = '{8'h00, 8'h00, 8'h78, 8'h00, 8'h20, 8'h04};
    bus.BUS_ADDR = 8'h00; bus.BUS_WE = 0; bus.INT_ACK = 0;
    RESET = 1;
    repeat (2) @(posedge CLK);
    #1;
    RESET = 0;
    q.delete(); shadow_m = '0; ovf_m = 0; inten_m = 1; int_m = 0;
    n_cmp++;
    if (bus.INT_RAISE !== 1'b0) begin
      n_err++; $display("FAIL reset_int: got %b want 0", bus.INT_RAISE);
    end
    n_cmp++;
    if (bus_data !== 8'hFF) begin
      n_err++; $display("FAIL reset_hiz: got %h want FF (undriven)", bus_data);
    end
    for (int i = 0; i < 6; i++) begin
      rd(BASE + 8'(i), v);
      n_cmp++;
      if (v !== exp[i]) begin
        n_err++; $display("FAIL reset_reg%0d: got %h want %h", i, v, exp[i]);
      end
    end
  endtask

  task automatic test_single_push();
    logic [7:0] v;
    logic [7:0] exp [5];
    ent_t p;
    exp = '{8'h0B, 8'h0A, 8'h64, 8'h03, 8'h01};
    p = '{st: 4'hB, x: 8'd10, y: 8'd20, z: 8'd3};
    step(1, p, 0, 8'h00, 8'h00, 0);
    n_cmp++;
    if (bus.INT_RAISE !== 1'b1) begin
      n_err++; $display("FAIL push_int: got %b want 1", bus.INT_RAISE);
    end
    for (int i = 0; i < 5; i++) begin
      rd(BASE + 8'(i), v);
      n_cmp++;
      if (v !== exp[i]) begin
        n_err++; $display("FAIL push_reg%0d: got %h want %h", i, v, exp[i]);
      end
    end
    step(0, rnd(), 0, 8'h00, 8'h00, 1);
    n_cmp++;
    if (bus.INT_RAISE !== 1'b0) begin
      n_err++; $display("FAIL ack_int: got %b want 0", bus.INT_RAISE);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] v;
    ent_t p;
    step(0, rnd(), 1, CTRL_A, 8'h06, 0);
    for (int i = 1; i <= 5; i++) begin
      p = rnd(); p.x = 8'(i);
      step(1, p, 0, 8'h00, 8'h00, 0);
    end
    rd(BASE + 8'd4, v);
    n_cmp++;
    if (v !== 8'hC4) begin
      n_err++; $display("FAIL ovf_flags: got %h want C4", v);
    end
    for (int i = 1; i <= 4; i++) begin
      rd(BASE + 8'd1, v);
      n_cmp++;
      if (v !== 8'(i)) begin
        n_err++; $display("FAIL ovf_drain%0d: got %h want %h", i, v, 8'(i));
      end
      step(0, rnd(), 1, CTRL_A, 8'h05, 0);
    end
    rd(BASE + 8'd1, v);
    n_cmp++;
    if (v !== 8'd5) begin
      n_err++; $display("FAIL ovf_shadow: got %h want 05", v);
    end
    rd(BASE + 8'd4, v);
    n_cmp++;
    if (v !== 8'hA0) begin
      n_err++; $display("FAIL ovf_empty_flags: got %h want A0", v);
    end
  endtask

  task automatic test_push_pop_full();
    logic [7:0] v, want_x;
    step(0, rnd(), 1, CTRL_A, 8'h06, 0);
    for (int i = 0; i < DEPTH; i++) step(1, rnd(), 0, 8'h00, 8'h00, 0);
    want_x = q[1].x;
    step(1, rnd(), 1, CTRL_A, 8'h05, 0);
    rd(BASE + 8'd4, v);
    n_cmp++;
    if (v !== 8'h44) begin
      n_err++; $display("FAIL pp_full_flags: got %h want 44", v);
    end
    rd(BASE + 8'd1, v);
    n_cmp++;
    if (v !== want_x) begin
      n_err++; $display("FAIL pp_full_head: got %h want %h", v, want_x);
    end
  endtask

  task automatic test_int_disable();
    logic [7:0] v;
    step(0, rnd(), 1, CTRL_A, 8'h06, 0);
    step(0, rnd(), 1, CTRL_A, 8'h00, 0);
    n_cmp++;
    if (bus.INT_RAISE !== 1'b0) begin
      n_err++; $display("FAIL inten_clear: got %b want 0", bus.INT_RAISE);
    end
    rd(CTRL_A, v);
    n_cmp++;
    if (v !== 8'h00) begin
      n_err++; $display("FAIL inten_ctrl: got %h want 00", v);
    end
    step(1, rnd(), 0, 8'h00, 8'h00, 0);
    n_cmp++;
    if (bus.INT_RAISE !== 1'b0) begin
      n_err++; $display("FAIL inten_masked: got %b want 0", bus.INT_RAISE);
    end
    rd(BASE + 8'd4, v);
    n_cmp++;
    if (v !== 8'h01) begin
      n_err++; $display("FAIL inten_count: got %h want 01", v);
    end
    step(1, rnd(), 1, CTRL_A, 8'h06, 0);
    n_cmp++;
    if (bus.INT_RAISE !== 1'b0) begin
      n_err++; $display("FAIL flush_push_int: got %b want 0", bus.INT_RAISE);
    end
    rd(BASE + 8'd4, v);
    n_cmp++;
    if (v !== 8'h20) begin
      n_err++; $display("FAIL flush_push_flags: got %h want 20", v);
    end
  endtask

  task automatic test_ignored();
    logic [7:0] v;
    step(1, rnd(), 0, 8'h00, 8'h00, 0);
    step(0, rnd(), 0, 8'h00, 8'h00, 1);
    step(0, rnd(), 1, BASE + 8'd2, 8'hFF, 0);
    rd(BASE + 8'd4, v);
    n_cmp++;
    if (v !== 8'h01) begin
      n_err++; $display("FAIL ign_flags: got %h want 01", v);
    end
    rd(CTRL_A, v);
    n_cmp++;
    if (v !== 8'h04) begin
      n_err++; $display("FAIL ign_ctrl: got %h want 04", v);
    end
    rd(BASE + 8'd6, v);
    n_cmp++;
    if (v !== 8'hFF) begin
      n_err++; $display("FAIL ign_hiz_hi: got %h want FF (undriven)", v);
    end
    rd(BASE - 8'd1, v);
    n_cmp++;
    if (v !== 8'hFF) begin
      n_err++; $display("FAIL ign_hiz_lo: got %h want FF (undriven)", v);
    end
    step(1, rnd(), 0, 8'h00, 8'h00, 1);
    n_cmp++;
    if (bus.INT_RAISE !== 1'b1) begin
      n_err++; $display("FAIL push_ack_int: got %b want 1", bus.INT_RAISE);
    end
  endtask

  task automatic test_random();
    logic [7:0] v, want, addr, wd;
    logic [2:0] o;
    int r;
    for (int it = 0; it < 400; it++) begin
      r = $urandom_range(0, 9);
      if (r < 3) begin
        o = 3'($urandom_range(0, 5));
        want = exp_rd(o);
        rd(BASE + 8'(o), v);
        n_cmp++;
        if (v !== want) begin
          n_err++; $display("FAIL rnd_read it=%0d ofs=%0d: got %h want %h", it, o, v, want);
        end
      end else begin
        if (r < 6) begin
          addr = ($urandom_range(0, 3) == 0) ? BASE + 8'($urandom_range(0, 4)) : CTRL_A;
          wd = {5'($urandom), 1'($urandom_range(0, 4) != 0),
                1'($urandom_range(0, 7) == 0), 1'($urandom)};
          step(1'($urandom), rnd(), 1, addr, wd, 1'($urandom_range(0, 3) == 0));
        end else begin
          step(1'($urandom), rnd(), 0, 8'($urandom_range(0, 8'h9F)), 8'h00,
               1'($urandom_range(0, 3) == 0));
        end
        n_cmp++;
        if (bus.INT_RAISE !== int_m) begin
          n_err++; $display("FAIL rnd_int it=%0d: got %b want %b", it, bus.INT_RAISE, int_m);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_overflow();
    test_push_pop_full();
    test_int_disable();
    test_ignored();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mouse_event_bus_bridge.md
Name: mouse_event_bus_bridge

Overview:
- Parametrised memory-mapped bridge between the PS/2 mouse transceiver and the processor data bus.
- Captures every mouse packet (status, X, Y, Z) into a small event FIFO, so no movement is lost between processor reads.
- Exposes the FIFO head, FIFO flags and a control register at a configurable base address.
- Raises a maskable interrupt with explicit acknowledge.

Parameters:
- BASE_ADDR, 8'hA0, bus address of register offset 0.
- FIFO_DEPTH, 4, number of event entries; power of two, minimum 2.
- COORD_W, 8, width of X/Y/Z fields; at most 8, zero-extended onto the bus.
- STATUS_W, 4, width of the status field; at most 8.
- Y_ORIGIN, 120, constant used for the Y transform.
- Y_INVERT, 1, 1 = bus Y reads Y_ORIGIN-Y (mod 2^COORD_W); 0 = raw Y.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  synchronous, active-high reset.
- BUS_DATA  inout  8  shared processor data bus.
- BUS_ADDR  in  8  processor address.
- BUS_WE  in  1  processor write strobe.
- SEND_INTERRUPT  in  1  one-cycle pulse from transceiver: new packet valid.
- MOUSE_STATUS  in  STATUS_W  packet status (buttons, initialised flag).
- MOUSE_X  in  COORD_W  packet X position.
- MOUSE_Y  in  COORD_W  packet Y position.
- MOUSE_Z  in  COORD_W  packet wheel value.
- INT_RAISE  out  1  interrupt request to processor.
- INT_ACK  in  1  interrupt acknowledge from processor.

Behaviour:
- Reset (all registers, one cycle):
  - FIFO empty, overflow=0.
  - Control register 8'h04 (interrupt enabled).
  - Shadow entry all zeros.
  - INT_RAISE=0.
  - Bus drive disabled.
- Push:
  - On a SEND_INTERRUPT cycle, {MOUSE_STATUS, MOUSE_X, MOUSE_Y, MOUSE_Z} is written at the tail and the count increments.
  - The shadow entry is updated with the same values.
- Full: the push is discarded, the FIFO is unchanged, overflow (sticky) is set. The shadow entry still updates.
- Register map (offset from BASE_ADDR):
  - +0 STATUS, +1 X, +2 Y (transformed per Y_INVERT), +3 Z.
    - These return the FIFO head when count>0, otherwise the shadow entry.
  - +4 FLAGS, read-only: {overflow, full, empty, count[4:0]}.
  - +5 CTRL, read/write: bit0 POP (self-clearing), bit1 FLUSH (self-clearing), bit2 INT_EN. Reads return {5'b0, INT_EN, 2'b00}.
- Read:
  - Condition: BUS_WE=0 and BUS_ADDR in BASE_ADDR..BASE_ADDR+5.
  - The output register and drive enable are loaded on that CLK edge, so BUS_DATA is valid one cycle after the address is presented.
  - Otherwise BUS_DATA is high-impedance from the next cycle.
  - Reads never modify state.
- Write:
  - Only BUS_WE=1 with BUS_ADDR=BASE_ADDR+5 has effect; writes to other offsets are ignored.
  - Drive enable is deasserted on any write cycle.
- POP:
  - Advances the head one cycle after the write.
  - Ignored when empty.
- Push and pop in the same cycle:
  - Both occur and the count is unchanged.
  - When full, both still succeed and overflow is not set.
  - When empty, only the push occurs.
- FLUSH:
  - Empties the FIFO and clears overflow.
  - Flush beats a same-cycle push; that push is discarded, but the shadow entry still updates.
- Interrupt:
  - INT_RAISE is set on any cycle a push succeeds and INT_EN=1.
  - Otherwise it is cleared on INT_ACK.
  - Push and INT_ACK in the same cycle leave INT_RAISE=1.
  - Writing INT_EN=0 clears INT_RAISE on the next cycle.
- Pointers wrap modulo FIFO_DEPTH. Count is held in log2(FIFO_DEPTH)+1 bits.

Decomposition:
- Package mouse_bus_pkg holds:
  - Register offset constants (OFS_STATUS..OFS_CTRL).
  - CTRL bit indices (CTRL_POP, CTRL_FLUSH, CTRL_INTEN).
  - FLAGS bit positions.
  - Packed event-entry width function (STATUS_W+3*COORD_W).
- Sub-module mouse_evt_fifo: synchronous single-clock FIFO.
  - Parameters: WIDTH, DEPTH.
  - Ports: push, pop, flush, head data, count, full, empty.
- The bridge holds the address decode, shadow entry, control register, interrupt logic and tri-state driver.

Test Plan:
- Reset, then read +0..+5 -> 0x00, 0x00, 0x78 (120-0), 0x00, 0x20 (empty), 0x04; INT_RAISE=0.
- Push one packet (status 4'hB, X=10, Y=20, Z=3) -> INT_RAISE=1 next cycle.
  - Reads: +0=0x0B, +1=0x0A, +2=0x64, +3=0x03, +4=0x01.
  - INT_ACK -> INT_RAISE=0.
- Push 5 packets X=1..5 with FIFO_DEPTH=4 -> FLAGS=0xC4 (overflow, full, count 4).
  - Read X then POP, repeated -> 1,2,3,4, then the shadow value 5 with FLAGS=0xA0.
- Push and POP write on the same cycle with FIFO full -> count stays 4, overflow stays 0, the head advances by one.
- Write CTRL=0x00, then push -> INT_RAISE stays 0, FLAGS count=1.
  - Write CTRL=0x06 together with a push -> count=0, overflow=0, INT_RAISE stays 0.
- Write to +2, and read address BASE_ADDR+6 -> no state change; BUS_DATA stays high-impedance.
  - Push coinciding with INT_ACK -> INT_RAISE stays 1.
